// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: pcsrc encodings and parameter defaults.
package pc_seq_pkg;

   localparam int unsigned ADDR_W_DEF    = 10;
   localparam int unsigned RAS_DEPTH_DEF = 4;
   localparam int unsigned RESET_PC_DEF  = 0;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_JMP = 2'b10,
      PCSRC_RET = 2'b11
   } pcsrc_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest entry;
// push and pop together replace the top in place. Entry storage is not reset.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = RAS_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   sp_q, sp_d, top_idx, wr_idx;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              ovf_q, ovf_d, unf_q, unf_d, wr_en;

   // sp_q is the next free slot; the top lives one below it (wraps with the pointer)
   assign top_idx = sp_q - PtrW'(1);
   assign top     = mem_q[top_idx];
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CntW'(DEPTH));
   assign ovf     = ovf_q;
   assign unf     = unf_q;

   // Next pointer/count, write enable and pulse flags from push/pop
   always_comb begin
      sp_d   = sp_q;
      cnt_d  = cnt_q;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      wr_en  = 1'b0;
      wr_idx = sp_q;
      if (push && pop) begin
         wr_en = 1'b1;
         if (empty) begin
            // Nothing to pop: behaves as a plain push plus an underflow pulse
            sp_d  = sp_q + PtrW'(1);
            cnt_d = cnt_q + CntW'(1);
            unf_d = 1'b1;
         end else begin
            wr_idx = top_idx;
         end
      end else if (push) begin
         wr_en = 1'b1;
         sp_d  = sp_q + PtrW'(1);
         if (full) ovf_d = 1'b1;
         else      cnt_d = cnt_q + CntW'(1);
      end else if (pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   // Pointer, count and pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entry storage, written on push or replace
   always_ff @(posedge clk) begin
      if (!reset && wr_en) mem_q[wr_idx] <= din;
   end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with seq/branch/jump/return selection.
// Define PC_SEQ_RAS_EN to include the return-address stack; without it,
// return acts as seq, jal is ignored and the stack flags are constant.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
   parameter int unsigned RESET_PC  = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [1:0]        pcsrc,
   input  logic [15:0]       immediate,
   input  logic [ADDR_W-1:0] address,
   input  logic              jal,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
);

   logic [ADDR_W-1:0] pc_q, pc_plus1, ret_target;

   assign pc       = pc_q;
   assign pc_plus1 = pc_q + ADDR_W'(1);

`ifdef PC_SEQ_RAS_EN
   logic [ADDR_W-1:0] ras_top;
   logic              ras_push, ras_pop;

   assign ras_push   = !stall && jal;
   assign ras_pop    = !stall && (pcsrc == PCSRC_RET);
   assign ret_target = ras_empty ? pc_plus1 : ras_top;

   pc_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc_plus1),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ras_ovf),
      .unf   (ras_unf)
   );
`else
   logic unused_jal;

   assign unused_jal = jal;
   assign ret_target = pc_plus1;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign ras_ovf    = 1'b0;
   assign ras_unf    = 1'b0;
`endif

   // Next-PC select; all sums wrap modulo 2^ADDR_W
   always_comb begin
      next_pc = pc_plus1;
      unique case (pcsrc_e'(pcsrc))
         PCSRC_SEQ: next_pc = pc_plus1;
         PCSRC_BR:  next_pc = ADDR_W'(immediate);
         PCSRC_JMP: next_pc = pc_plus1 + address;
         PCSRC_RET: next_pc = ret_target;
         default:   next_pc = pc_plus1;
      endcase
   end

   // PC register; reset wins over stall
   always_ff @(posedge clk) begin
      if (reset)       pc_q <= ADDR_W'(RESET_PC);
      else if (!stall) pc_q <= next_pc;
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq. Stack scenarios run only when the
// design is built with PC_SEQ_RAS_EN; otherwise the constant-flag build is checked.
module tb_pc_seq;
   import pc_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset, stall, jal;
   logic [1:0] pcsrc;
   logic [15:0] immediate;
   logic [9:0] address;
   logic [9:0] pc, next_pc;
   logic       ras_empty, ras_full, ras_ovf, ras_unf;

   int checks = 0;
   int errors = 0;

   pc_seq dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .pcsrc     (pcsrc),
      .immediate (immediate),
      .address   (address),
      .jal       (jal),
      .pc        (pc),
      .next_pc   (next_pc),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; jal = 1'b0; pcsrc = PCSRC_SEQ;
      step();
      reset = 1'b0;
   endtask

   task automatic set_pc(input logic [9:0] v);
      stall = 1'b0; jal = 1'b0; pcsrc = PCSRC_BR; immediate = {6'h0, v};
      step();
      pcsrc = PCSRC_SEQ;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b1; jal = 1'b1; pcsrc = PCSRC_RET;
      immediate = 16'h0; address = 10'h0;
      step();
      checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
      checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got e%b f%b o%b u%b want e1 f0 o0 u0",
                            ras_empty, ras_full, ras_ovf, ras_unf);
      end
      reset = 1'b0; stall = 1'b0; jal = 1'b0; pcsrc = PCSRC_SEQ;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (pc !== 10'(i) || ras_empty !== 1'b1) begin
            errors++; $display("FAIL seq_%0d: got pc=%0h e=%b want pc=%0h e=1", i, pc, ras_empty, i);
         end
      end
   endtask

   task automatic test_branch_wrap();
      set_pc(10'd5);
      checks++; if (pc !== 10'd5) begin errors++; $display("FAIL set_pc5: got %0h want 5", pc); end
      pcsrc = PCSRC_BR; immediate = 16'hF3FF;
      #1;
      checks++; if (next_pc !== 10'h3FF) begin errors++; $display("FAIL br_next: got %0h want 3ff", next_pc); end
      step();
      checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL br_pc: got %0h want 3ff", pc); end
      pcsrc = PCSRC_SEQ;
      #1;
      checks++; if (next_pc !== 10'h000) begin errors++; $display("FAIL wrap_next: got %0h want 0", next_pc); end
      step();
      checks++; if (pc !== 10'h000) begin errors++; $display("FAIL wrap_pc: got %0h want 0", pc); end
   endtask

   task automatic test_jump();
      do_reset();
      set_pc(10'd8);
      pcsrc = PCSRC_JMP; address = 10'd4; jal = 1'b1;
      #1;
      checks++; if (next_pc !== 10'd13) begin errors++; $display("FAIL jmp_next: got %0h want d", next_pc); end
      step();
      jal = 1'b0;
      checks++; if (pc !== 10'd13) begin errors++; $display("FAIL jmp_pc: got %0h want d", pc); end
`ifdef PC_SEQ_RAS_EN
      checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL jal_push: empty=%b want 0", ras_empty); end
      pcsrc = PCSRC_RET;
      #1;
      checks++; if (next_pc !== 10'd9) begin errors++; $display("FAIL ret_next: got %0h want 9", next_pc); end
      step();
      checks++; if (pc !== 10'd9 || ras_empty !== 1'b1) begin
         errors++; $display("FAIL ret_pc: got pc=%0h e=%b want pc=9 e=1", pc, ras_empty);
      end
`else
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL jal_ignored: empty=%b want 1", ras_empty); end
`endif
      // Jump sum wraps: 3ff + 1 + 3ff = 3ff mod 2^10
      set_pc(10'h3FF);
      pcsrc = PCSRC_JMP; address = 10'h3FF;
      step();
      checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL jmp_wrap: got %0h want 3ff", pc); end
      pcsrc = PCSRC_SEQ; address = 10'h0;
   endtask

   task automatic test_stall();
      logic [9:0] base;
      do_reset();
      set_pc(10'd20);
`ifdef PC_SEQ_RAS_EN
      jal = 1'b1;
      step();
      jal = 1'b0;
      checks++; if (pc !== 10'd21 || ras_empty !== 1'b0) begin
         errors++; $display("FAIL stall_setup: got pc=%0h e=%b want pc=15 e=0", pc, ras_empty);
      end
      base = 10'd21;
`else
      base = 10'd20;
`endif
      stall = 1'b1; pcsrc = PCSRC_RET; jal = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== base || ras_ovf !== 1'b0 || ras_unf !== 1'b0 || ras_full !== 1'b0) begin
            errors++; $display("FAIL stall_hold_%0d: got pc=%0h o=%b u=%b f=%b want pc=%0h o0 u0 f0",
                               i, pc, ras_ovf, ras_unf, ras_full, base);
         end
`ifdef PC_SEQ_RAS_EN
         checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL stall_cnt_%0d: e=%b want 0", i, ras_empty); end
`endif
      end
      stall = 1'b0;
`ifdef PC_SEQ_RAS_EN
      // Return + jal on a non-empty stack: jump to old top, top becomes pc+1
      #1;
      checks++; if (next_pc !== 10'd21) begin errors++; $display("FAIL repl_next: got %0h want 15", next_pc); end
      step();
      jal = 1'b0;
      checks++; if (pc !== 10'd21 || ras_empty !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
         errors++; $display("FAIL repl: got pc=%0h e=%b o=%b u=%b want pc=15 e0 o0 u0",
                            pc, ras_empty, ras_ovf, ras_unf);
      end
      step();
      checks++; if (pc !== 10'd22 || ras_empty !== 1'b1) begin
         errors++; $display("FAIL repl_pop: got pc=%0h e=%b want pc=16 e=1", pc, ras_empty);
      end
      stall = 1'b1;
      step();
      checks++; if (pc !== 10'd22 || ras_unf !== 1'b0) begin
         errors++; $display("FAIL stall_unf: got pc=%0h u=%b want pc=16 u=0", pc, ras_unf);
      end
      stall = 1'b0;
      step();
      checks++; if (pc !== 10'd23 || ras_unf !== 1'b1) begin
         errors++; $display("FAIL unf_pulse: got pc=%0h u=%b want pc=17 u=1", pc, ras_unf);
      end
      pcsrc = PCSRC_SEQ;
      step();
      checks++; if (pc !== 10'd24 || ras_unf !== 1'b0) begin
         errors++; $display("FAIL unf_clear: got pc=%0h u=%b want pc=18 u=0", pc, ras_unf);
      end
`else
      step();
      jal = 1'b0;
      checks++; if (pc !== 10'd21) begin errors++; $display("FAIL stall_release: got %0h want 15", pc); end
`endif
      pcsrc = PCSRC_SEQ;
   endtask

`ifdef PC_SEQ_RAS_EN
   task automatic test_overflow_underflow();
      do_reset();
      jal = 1'b1; pcsrc = PCSRC_SEQ;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (pc !== 10'(i + 1) || ras_ovf !== (i == 4) || ras_full !== (i >= 3)) begin
            errors++; $display("FAIL push_%0d: got pc=%0h o=%b f=%b want pc=%0h o=%b f=%b",
                               i, pc, ras_ovf, ras_full, i + 1, i == 4, i >= 3);
         end
      end
      jal = 1'b0; pcsrc = PCSRC_RET;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (pc !== 10'(5 - k) || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            errors++; $display("FAIL pop_%0d: got pc=%0h o=%b u=%b want pc=%0h o0 u0",
                               k, pc, ras_ovf, ras_unf, 5 - k);
         end
      end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL drained: e=%b want 1", ras_empty); end
      step();
      checks++; if (pc !== 10'd3 || ras_unf !== 1'b1) begin
         errors++; $display("FAIL pop_empty: got pc=%0h u=%b want pc=3 u=1", pc, ras_unf);
      end
      pcsrc = PCSRC_SEQ;
      step();
      checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL unf_one_cycle: u=%b want 0", ras_unf); end
   endtask

   task automatic test_ret_jal_empty();
      do_reset();
      set_pc(10'd40);
      pcsrc = PCSRC_RET; jal = 1'b1;
      #1;
      checks++; if (next_pc !== 10'd41) begin errors++; $display("FAIL rj_next: got %0h want 29", next_pc); end
      step();
      jal = 1'b0;
      checks++; if (pc !== 10'd41 || ras_unf !== 1'b1 || ras_empty !== 1'b0 || ras_ovf !== 1'b0) begin
         errors++; $display("FAIL rj_empty: got pc=%0h u=%b e=%b o=%b want pc=29 u1 e0 o0",
                            pc, ras_unf, ras_empty, ras_ovf);
      end
      step();
      checks++; if (pc !== 10'd41 || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
         errors++; $display("FAIL rj_pop: got pc=%0h e=%b u=%b want pc=29 e1 u0", pc, ras_empty, ras_unf);
      end
      pcsrc = PCSRC_SEQ;
   endtask

   task automatic test_reset_mid();
      do_reset();
      jal = 1'b1; pcsrc = PCSRC_SEQ;
      step();
      step();
      jal = 1'b1; stall = 1'b1; pcsrc = PCSRC_RET; reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0; jal = 1'b0;
      checks++; if (pc !== 10'd0 || ras_empty !== 1'b1) begin
         errors++; $display("FAIL mid_reset: got pc=%0h e=%b want pc=0 e=1", pc, ras_empty);
      end
      step();
      checks++; if (pc !== 10'd1 || ras_unf !== 1'b1) begin
         errors++; $display("FAIL mid_reset_ret: got pc=%0h u=%b want pc=1 u=1", pc, ras_unf);
      end
      pcsrc = PCSRC_SEQ;
   endtask
`else
   task automatic test_no_ras();
      do_reset();
      set_pc(10'd7);
      pcsrc = PCSRC_RET; jal = 1'b1;
      #1;
      checks++; if (next_pc !== 10'd8) begin errors++; $display("FAIL noras_next: got %0h want 8", next_pc); end
      step();
      checks++; if (pc !== 10'd8) begin errors++; $display("FAIL noras_pc: got %0h want 8", pc); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            errors++; $display("FAIL noras_flags_%0d: got e%b f%b o%b u%b want e1 f0 o0 u0",
                               i, ras_empty, ras_full, ras_ovf, ras_unf);
         end
      end
      jal = 1'b0; pcsrc = PCSRC_SEQ;
   endtask
`endif

   initial begin
      reset = 1'b1; stall = 1'b0; jal = 1'b0; pcsrc = PCSRC_SEQ;
      immediate = 16'h0; address = 10'h0;
      test_reset();
      test_branch_wrap();
      test_jump();
      test_stall();
`ifdef PC_SEQ_RAS_EN
      test_overflow_underflow();
      test_ret_jal_empty();
      test_reset_mid();
`else
      test_no_ras();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter ADDR_W, default 10: PC and jump-address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, >=2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  when high, PC and stack hold.
REQ-007 pcsrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 return.
REQ-008 immediate  input  16  absolute branch target.
REQ-009 address  input  ADDR_W  jump offset, unsigned.
REQ-010 jal  input  1  link: push PC+1 onto the return stack this cycle.
REQ-011 pc  output  ADDR_W  registered current PC.
REQ-012 next_pc  output  ADDR_W  combinational value pc takes at the next unstalled edge.
REQ-013 ras_empty  output  1  stack holds zero entries.
REQ-014 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-015 ras_ovf  output  1  registered one-cycle pulse: a push occurred while full.
REQ-016 ras_unf  output  1  registered one-cycle pulse: a pop occurred while empty.

Function
REQ-017 All sums are modulo 2^ADDR_W; carries out are discarded, so PC max+1 wraps to 0.
REQ-018 seq (00): next_pc = pc+1.
REQ-019 branch (01): next_pc = immediate[ADDR_W-1:0]; upper immediate bits are ignored.
REQ-020 jump (10): next_pc = pc+1+address.
REQ-021 return (11): next_pc = top of stack; if the stack is empty, next_pc = pc+1.
REQ-022 An unstalled edge loads pc <= next_pc; latency is one cycle from select to pc.
REQ-023 stall=1 holds pc, stack contents, pointer and count.
REQ-024 stall=1 forces ras_ovf and ras_unf to 0 on that edge; no push or pop occurs.
REQ-025 An unstalled jal=1 pushes pc+1, which is the value of the current pc, not of next_pc.
REQ-026 Push while full overwrites the oldest entry (circular).
REQ-027 Push while full leaves the count at RAS_DEPTH and pulses ras_ovf.
REQ-028 Return while empty pops nothing and pulses ras_unf.
REQ-029 jal with return in the same cycle: next_pc takes the old top.
REQ-030 In that case the top is replaced by pc+1, the count is unchanged, and no ovf or unf pulse is raised.
REQ-031 If that same case occurs with the stack empty, pc+1 is pushed, ras_unf pulses and next_pc = pc+1.
REQ-032 ras_empty and ras_full are combinational decodes of the registered count.

Reset
REQ-033 On reset edge: pc = RESET_PC, count = 0, ras_ovf = ras_unf = 0, ras_empty = 1, ras_full = 0.
REQ-034 Reset overrides stall, jal and pcsrc.
REQ-035 Reset applied mid-sequence discards all stack contents.
REQ-036 Stack entry storage need not be cleared on reset.

Configuration
REQ-037 Macro PC_SEQ_RAS_EN defined: the return stack and all behaviour above are present.
REQ-038 Macro absent: no stack storage; pcsrc=11 behaves as seq; jal is ignored.
REQ-039 Macro absent: ras_empty = 1, ras_full = 0, ras_ovf = ras_unf = 0, constant.

Structure
REQ-040 Shared package pc_seq_pkg holds the pcsrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JMP, PCSRC_RET) and the default parameter constants.
REQ-041 The stack is a sub-module pc_ras (push/pop/replace, count, top, ovf/unf), instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-042 Reset, then 3 cycles of seq -> pc = 0,1,2,3; ras_empty = 1.
REQ-043 pc = 5, branch with immediate = 16'hF3FF -> pc = 10'h3FF; next cycle seq -> pc = 0 (wrap).
REQ-044 pc = 8, jump with address = 4 plus jal -> pc = 13, stack top = 9.
REQ-044a Continuing REQ-044, return -> pc = 9, ras_empty = 1.
REQ-045 With RAS_DEPTH = 4, five jal pushes at pc = 0..4 -> ras_ovf pulses once on the fifth.
REQ-045a Continuing REQ-045, four returns yield 5,4,3,2; a fifth return gives ras_unf and pc+1.
REQ-046 stall = 1 for 3 cycles during a jal/return -> pc and count unchanged, no pulses; resume on release.
REQ-047 Build without PC_SEQ_RAS_EN: return at pc = 7 -> pc = 8; ras flags constant.
